// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared lamp encodings, phase codes and small helpers for the intersection scheduler.
package traffic_pkg;

    localparam logic [1:0] LAMP_RED = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_GRN = 2'b10;

    localparam int ROAD_EW = 0;
    localparam int ROAD_NS = 1;
    localparam int N_ROADS = 2;

    typedef enum logic [2:0] {
        EW_GREEN  = 3'd0,
        EW_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        NS_GREEN  = 3'd3,
        NS_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        EMERG     = 3'd6
    } phase_t;

    function automatic logic [7:0] sat_add8(input int a, input int b);
        int s;
        s = a + b;
        if (s > 255) return 8'hFF;
        return 8'(s);
    endfunction

    function automatic logic [1:0] ew_lamp(input phase_t p);
        case (p)
            EW_GREEN:  return LAMP_GRN;
            EW_YELLOW: return LAMP_YEL;
            default:   return LAMP_RED;
        endcase
    endfunction

    function automatic logic [1:0] ns_lamp(input phase_t p);
        case (p)
            NS_GREEN:  return LAMP_GRN;
            NS_YELLOW: return LAMP_YEL;
            default:   return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_timer.sv
// Tick-paced 8-bit phase down-counter; expire marks the last tick of a phase.
module phase_timer #(
    parameter logic [7:0] RESET_VAL = 8'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       expire
);

    logic [7:0] cnt_reg;

    // Holds at 1 on its final tick; the FSM reloads it in that same clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= RESET_VAL;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (tick && (cnt_reg > 8'd1)) begin
            cnt_reg <= cnt_reg - 8'd1;
        end
    end

    assign count  = cnt_reg;
    assign expire = tick & (cnt_reg == 8'd1);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection sequencer: tick-timed phases, pedestrian green extension and urgency preemption.
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int T_GREEN_EW = 45,
    parameter int T_GREEN_NS = 40,
    parameter int T_YELLOW   = 5,
    parameter int T_ALLRED   = 2,
    parameter int T_PED_EXT  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       urgency,
    input  logic       ped_req_ew,
    input  logic       ped_req_ns,
    output logic [1:0] east_west,
    output logic [1:0] south_north,
    output logic [7:0] countdown,
    output logic       walk_ew,
    output logic       walk_ns,
    output logic [2:0] phase
);

    if (T_GREEN_EW < 1 || T_GREEN_EW > 255 || T_GREEN_NS < 1 || T_GREEN_NS > 255 ||
        T_YELLOW < 1 || T_YELLOW > 255 || T_ALLRED < 1 || T_ALLRED > 255 ||
        T_PED_EXT < 0 || T_PED_EXT > 255) begin : g_param_err
        $error("intersection_phase_scheduler: timing parameter out of range");
    end

    localparam logic [7:0] DUR_GREEN_EW = 8'(T_GREEN_EW);
    localparam logic [7:0] DUR_GREEN_NS = 8'(T_GREEN_NS);
    localparam logic [7:0] DUR_YELLOW   = 8'(T_YELLOW);
    localparam logic [7:0] DUR_ALLRED   = 8'(T_ALLRED);
    localparam logic [7:0] EXT_GREEN_EW = sat_add8(T_GREEN_EW, T_PED_EXT);
    localparam logic [7:0] EXT_GREEN_NS = sat_add8(T_GREEN_NS, T_PED_EXT);

    phase_t               state_reg, state_next;
    logic [N_ROADS-1:0]   ped_req;
    logic [N_ROADS-1:0]   pending_reg, pending_next, pending_clear;
    logic                 timer_load;
    logic [7:0]           timer_load_val;
    logic                 timer_expire;
    logic [7:0]           timer_count;
    logic [1:0]           ew_lamp_reg, ns_lamp_reg;
    logic                 walk_ew_reg, walk_ns_reg;

    phase_timer #(
        .RESET_VAL (DUR_ALLRED)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .load     (timer_load),
        .load_val (timer_load_val),
        .count    (timer_count),
        .expire   (timer_expire)
    );

    assign ped_req = {ped_req_ns, ped_req_ew};

    // A new request beats a same-clk clear, so it survives to the next green.
    for (genvar gi = 0; gi < N_ROADS; gi++) begin : g_pending
        assign pending_next[gi] = ped_req[gi] | (pending_reg[gi] & ~pending_clear[gi]);
    end

    always_comb begin
        state_next     = state_reg;
        timer_load     = 1'b0;
        timer_load_val = 8'd0;
        pending_clear  = '0;
        case (state_reg)
            EW_GREEN: begin
                if (urgency || timer_expire) begin
                    state_next     = EW_YELLOW;
                    timer_load     = 1'b1;
                    timer_load_val = DUR_YELLOW;
                end
            end
            EW_YELLOW: begin
                if (timer_expire) begin
                    state_next     = ALLRED_A;
                    timer_load     = 1'b1;
                    timer_load_val = DUR_ALLRED;
                end
            end
            ALLRED_A: begin
                if (timer_expire) begin
                    timer_load = 1'b1;
                    if (urgency) begin
                        state_next     = EMERG;
                        timer_load_val = 8'd0;
                    end else begin
                        state_next     = NS_GREEN;
                        timer_load_val = pending_reg[ROAD_NS] ? EXT_GREEN_NS : DUR_GREEN_NS;
                        pending_clear[ROAD_NS] = 1'b1;
                    end
                end
            end
            NS_GREEN: begin
                if (urgency || timer_expire) begin
                    state_next     = NS_YELLOW;
                    timer_load     = 1'b1;
                    timer_load_val = DUR_YELLOW;
                end
            end
            NS_YELLOW: begin
                if (timer_expire) begin
                    state_next     = ALLRED_B;
                    timer_load     = 1'b1;
                    timer_load_val = DUR_ALLRED;
                end
            end
            ALLRED_B: begin
                if (timer_expire) begin
                    timer_load = 1'b1;
                    if (urgency) begin
                        state_next     = EMERG;
                        timer_load_val = 8'd0;
                    end else begin
                        state_next     = EW_GREEN;
                        timer_load_val = pending_reg[ROAD_EW] ? EXT_GREEN_EW : DUR_GREEN_EW;
                        pending_clear[ROAD_EW] = 1'b1;
                    end
                end
            end
            EMERG: begin
                // Counter sits at 0 here, so ticks can neither count nor expire.
                if (!urgency) begin
                    state_next     = ALLRED_B;
                    timer_load     = 1'b1;
                    timer_load_val = DUR_ALLRED;
                end
            end
            default: begin
                state_next     = ALLRED_B;
                timer_load     = 1'b1;
                timer_load_val = DUR_ALLRED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ALLRED_B;
            pending_reg <= '0;
            ew_lamp_reg <= LAMP_RED;
            ns_lamp_reg <= LAMP_RED;
            walk_ew_reg <= 1'b0;
            walk_ns_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            ew_lamp_reg <= ew_lamp(state_next);
            ns_lamp_reg <= ns_lamp(state_next);
            walk_ew_reg <= (state_next == EW_GREEN);
            walk_ns_reg <= (state_next == NS_GREEN);
        end
    end

    assign east_west   = ew_lamp_reg;
    assign south_north = ns_lamp_reg;
    assign walk_ew     = walk_ew_reg;
    assign walk_ns     = walk_ns_reg;
    assign phase       = state_reg;
    assign countdown   = timer_count;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench: expected phase entries are queued up front, a monitor checks each phase change and countdown.
module tb_intersection_phase_scheduler;
    import traffic_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       urgency;
    logic       ped_req_ew;
    logic       ped_req_ns;
    logic [1:0] east_west;
    logic [1:0] south_north;
    logic [7:0] countdown;
    logic       walk_ew;
    logic       walk_ns;
    logic [2:0] phase;

    intersection_phase_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .urgency     (urgency),
        .ped_req_ew  (ped_req_ew),
        .ped_req_ns  (ped_req_ns),
        .east_west   (east_west),
        .south_north (south_north),
        .countdown   (countdown),
        .walk_ew     (walk_ew),
        .walk_ns     (walk_ns),
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ph;
        logic [1:0] ew;
        logic [1:0] ns;
        logic [7:0] cd;
        logic       wew;
        logic       wns;
        int         dur;
    } exp_t;

    exp_t exp_q[$];
    int   n_total  = 0;
    int   n_passed = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Lamp table written out per phase; dur < 0 means the phase length is not checked.
    task automatic push(input phase_t ph, input int cd, input int dur);
        exp_t e;
        e.ph  = ph;
        e.cd  = 8'(cd);
        e.dur = dur;
        e.wew = (ph == EW_GREEN);
        e.wns = (ph == NS_GREEN);
        case (ph)
            EW_GREEN:  begin e.ew = 2'b10; e.ns = 2'b00; end
            EW_YELLOW: begin e.ew = 2'b01; e.ns = 2'b00; end
            NS_GREEN:  begin e.ew = 2'b00; e.ns = 2'b10; end
            NS_YELLOW: begin e.ew = 2'b00; e.ns = 2'b01; end
            default:   begin e.ew = 2'b00; e.ns = 2'b00; end
        endcase
        exp_q.push_back(e);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    // Monitor: a phase change is the DUT's output event; also tracks countdown on every tick.
    initial begin : monitor
        logic [2:0] cur_phase;
        int         cur_dur;
        int         tcount;
        int         exp_cd;
        exp_t       it;
        cur_phase = 3'd5;
        cur_dur   = 2;
        tcount    = 0;
        exp_cd    = 2;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (tick) tcount++;
                if (phase != cur_phase) begin
                    if (cur_dur >= 0) check($sformatf("ticks_in_phase%0d", cur_phase), tcount, cur_dur);
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_phase_change: got phase %0d with no expected entry", phase);
                        cur_dur = -1;
                        exp_cd  = countdown;
                    end else begin
                        it = exp_q.pop_front();
                        check("phase", phase, it.ph);
                        check("east_west", east_west, it.ew);
                        check("south_north", south_north, it.ns);
                        check("entry_countdown", countdown, it.cd);
                        check("walk_ew", walk_ew, it.wew);
                        check("walk_ns", walk_ns, it.wns);
                        cur_dur = it.dur;
                        exp_cd  = it.cd;
                    end
                    cur_phase = phase;
                    tcount    = 0;
                end else if (tick) begin
                    if (cur_phase != 3'd6) exp_cd--;
                    check("countdown", countdown, exp_cd);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n      = 1'b0;
        tick       = 1'b0;
        urgency    = 1'b0;
        ped_req_ew = 1'b0;
        ped_req_ns = 1'b0;

        // Normal cycle, then ped_req_ns extends one NS green only.
        push(EW_GREEN, 45, 45); push(EW_YELLOW, 5, 5); push(ALLRED_A, 2, 2);
        push(NS_GREEN, 40, 40); push(NS_YELLOW, 5, 5); push(ALLRED_B, 2, 2);
        push(EW_GREEN, 45, 45); push(EW_YELLOW, 5, 5); push(ALLRED_A, 2, 2);
        push(NS_GREEN, 50, 50); push(NS_YELLOW, 5, 5); push(ALLRED_B, 2, 2);
        // Urgency at countdown 30, EMERG, release with an EW request latched.
        push(EW_GREEN, 45, 15); push(EW_YELLOW, 5, 5); push(ALLRED_A, 2, 2);
        push(EMERG, 0, 3);      push(ALLRED_B, 2, 2);  push(EW_GREEN, 55, 55);
        push(EW_YELLOW, 5, 5);  push(ALLRED_A, 2, 2);
        // Pending NS was cleared earlier, so this green is plain 40; expiry+urgency coincide.
        push(NS_GREEN, 40, 40); push(NS_YELLOW, 5, -1);

        repeat (3) @(negedge clk);
        @(posedge clk) #1;
        check("reset_phase", phase, ALLRED_B);
        check("reset_countdown", countdown, 2);
        check("reset_east_west", east_west, 2'b00);
        check("reset_south_north", south_north, 2'b00);
        check("reset_walks", {walk_ew, walk_ns}, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        check("release_phase", phase, ALLRED_B);
        check("release_countdown", countdown, 2);
        mon_en = 1'b1;

        run_ticks(101);
        @(negedge clk) ped_req_ns = 1'b1;
        @(negedge clk) ped_req_ns = 1'b0;
        run_ticks(109);

        run_ticks(15);
        @(negedge clk) urgency = 1'b1;
        run_ticks(7);
        run_ticks(3);
        @(negedge clk) ped_req_ew = 1'b1;
        @(negedge clk) ped_req_ew = 1'b0;
        urgency = 1'b0;
        run_ticks(64);

        run_ticks(39);
        @(negedge clk) begin
            tick    = 1'b1;
            urgency = 1'b1;
        end
        @(negedge clk) begin
            tick    = 1'b0;
            urgency = 1'b0;
        end
        run_ticks(2);

        // Asynchronous reset between clock edges during NS_YELLOW.
        @(negedge clk) mon_en = 1'b0;
        check("pre_reset_phase", phase, NS_YELLOW);
        check("pre_reset_countdown", countdown, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_east_west", east_west, 2'b00);
        check("async_reset_south_north", south_north, 2'b00);
        check("async_reset_phase", phase, ALLRED_B);
        check("async_reset_countdown", countdown, 2);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        check("post_reset_phase", phase, ALLRED_B);
        check("post_reset_countdown", countdown, 2);
        check("post_reset_lamps", {east_west, south_north}, 4'b0000);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
